// File: rtl/bambu_offchip_mem_slave.sv
// Dual-channel off-chip memory slave answering the HLS Mout_* master bus with programmable latency.
// Optional feature: define MEM_SLAVE_PROTO_CHECK_EN to flag and drop simultaneous oe/we requests.
module bambu_offchip_mem_slave #(
    parameter int ADDR_W    = 11,
    parameter int DATA_W    = 8,
    parameter int SIZE_W    = 4,
    parameter int MEM_DEPTH = 512,
    parameter int BASE_ADDR = 0,
    parameter int READ_LAT  = 2,
    parameter int WRITE_LAT = 1
) (
    input  logic                  clock,
    input  logic                  reset,
    input  logic [1:0]            Mout_oe_ram,
    input  logic [1:0]            Mout_we_ram,
    input  logic [2*ADDR_W-1:0]   Mout_addr_ram,
    input  logic [2*DATA_W-1:0]   Mout_Wdata_ram,
    input  logic [2*SIZE_W-1:0]   Mout_data_ram_size,
    output logic [2*DATA_W-1:0]   M_Rdata_ram,
    output logic [1:0]            M_DataRdy,
    input  logic                  ld_en,
    input  logic [ADDR_W-1:0]     ld_addr,
    input  logic [DATA_W-1:0]     ld_data,
    output logic                  proto_err
);
    localparam int IDX_W = (MEM_DEPTH > 1) ? $clog2(MEM_DEPTH) : 1;
    localparam int CNT_W = 8;
    localparam logic [CNT_W-1:0] RD_LOAD = CNT_W'(READ_LAT - 1);
    localparam logic [CNT_W-1:0] WR_LOAD = CNT_W'(WRITE_LAT - 1);

    typedef enum logic [1:0] {IDLE, RD_WAIT, WR_WAIT, RESP} state_t;

    function automatic logic [DATA_W-1:0] size_mask(input logic [SIZE_W-1:0] s);
        logic [DATA_W:0] m;
        m = ((DATA_W+1)'(1) << s) - (DATA_W+1)'(1);
        if (32'(s) >= DATA_W) return '1;
        return m[DATA_W-1:0];
    endfunction

    function automatic logic in_window(input logic [ADDR_W-1:0] a);
        return (33'(a) >= 33'(BASE_ADDR)) && (33'(a) < 33'(BASE_ADDR) + 33'(MEM_DEPTH));
    endfunction

    function automatic logic [IDX_W-1:0] to_idx(input logic [ADDR_W-1:0] a);
        return IDX_W'(33'(a) - 33'(BASE_ADDR));
    endfunction

    logic [DATA_W-1:0] mem [MEM_DEPTH];

    state_t            state_q [2];
    logic [CNT_W-1:0]  cnt_q   [2];
    logic [IDX_W-1:0]  idx_q   [2];
    logic [SIZE_W-1:0] size_q  [2];
    logic [DATA_W-1:0] rdata_q [2];
    logic [1:0]        rdy_q;

    logic [ADDR_W-1:0] addr_c  [2];
    logic [DATA_W-1:0] wdata_c [2];
    logic [SIZE_W-1:0] size_c  [2];
    logic [IDX_W-1:0]  idx_c   [2];
    logic [DATA_W-1:0] wr_word [2];
    logic [IDX_W-1:0]  rd_idx  [2];
    logic [SIZE_W-1:0] rd_size [2];
    logic [DATA_W-1:0] rd_word [2];
    logic [1:0]        req_ok, rd_acc, wr_acc, rd_go, wr_go;
    logic              ld_ok;
    logic [IDX_W-1:0]  ld_idx;
`ifdef MEM_SLAVE_PROTO_CHECK_EN
    logic [1:0]        both_req;
    logic              proto_q;
`endif

    assign ld_ok  = ld_en && (33'(ld_addr) < 33'(MEM_DEPTH));
    assign ld_idx = IDX_W'(ld_addr);

    always_comb begin
        req_ok = '0;
        rd_acc = '0;
        wr_acc = '0;
        rd_go  = '0;
        wr_go  = '0;
`ifdef MEM_SLAVE_PROTO_CHECK_EN
        both_req = '0;
`endif
        for (int c = 0; c < 2; c++) begin
            addr_c[c]  = Mout_addr_ram[c*ADDR_W +: ADDR_W];
            wdata_c[c] = Mout_Wdata_ram[c*DATA_W +: DATA_W];
            size_c[c]  = Mout_data_ram_size[c*SIZE_W +: SIZE_W];
            idx_c[c]   = to_idx(addr_c[c]);
            req_ok[c]  = (state_q[c] == IDLE) && in_window(addr_c[c]);
`ifdef MEM_SLAVE_PROTO_CHECK_EN
            rd_acc[c]   = req_ok[c] & Mout_oe_ram[c] & ~Mout_we_ram[c];
            wr_acc[c]   = req_ok[c] & Mout_we_ram[c] & ~Mout_oe_ram[c];
            both_req[c] = req_ok[c] & Mout_we_ram[c] & Mout_oe_ram[c];
`else
            rd_acc[c] = req_ok[c] & Mout_oe_ram[c] & ~Mout_we_ram[c];
            wr_acc[c] = req_ok[c] & Mout_we_ram[c];
`endif
            wr_word[c] = (wdata_c[c] & size_mask(size_c[c])) | (mem[idx_c[c]] & ~size_mask(size_c[c]));
            rd_go[c] = (rd_acc[c] && READ_LAT == 1) || (state_q[c] == RD_WAIT && cnt_q[c] == CNT_W'(1));
            wr_go[c] = (wr_acc[c] && WRITE_LAT == 1) || (state_q[c] == WR_WAIT && cnt_q[c] == CNT_W'(1));
            rd_idx[c]  = (state_q[c] == IDLE) ? idx_c[c] : idx_q[c];
            rd_size[c] = (state_q[c] == IDLE) ? size_c[c] : size_q[c];
        end
        // Read data forwards same-edge commits in array priority order: loader, ch0, ch1.
        for (int c = 0; c < 2; c++) begin
            rd_word[c] = mem[rd_idx[c]];
            if (ld_ok && ld_idx == rd_idx[c]) rd_word[c] = ld_data;
            for (int k = 0; k < 2; k++) begin
                if (wr_acc[k] && idx_c[k] == rd_idx[c]) rd_word[c] = wr_word[k];
            end
        end
    end

    always_ff @(posedge clock) begin
        if (ld_ok) mem[ld_idx] <= ld_data;
        for (int c = 0; c < 2; c++) begin
            if (wr_acc[c]) mem[idx_c[c]] <= wr_word[c];
        end
    end

    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            rdy_q <= '0;
            for (int c = 0; c < 2; c++) begin
                state_q[c] <= IDLE;
                cnt_q[c]   <= '0;
                idx_q[c]   <= '0;
                size_q[c]  <= '0;
                rdata_q[c] <= '0;
            end
        end else begin
            for (int c = 0; c < 2; c++) begin
                rdy_q[c]   <= rd_go[c] | wr_go[c];
                rdata_q[c] <= rd_go[c] ? (rd_word[c] & size_mask(rd_size[c])) : '0;
                case (state_q[c])
                    IDLE: begin
                        if (rd_acc[c]) begin
                            idx_q[c]   <= idx_c[c];
                            size_q[c]  <= size_c[c];
                            cnt_q[c]   <= RD_LOAD;
                            state_q[c] <= (READ_LAT == 1) ? RESP : RD_WAIT;
                        end else if (wr_acc[c]) begin
                            idx_q[c]   <= idx_c[c];
                            size_q[c]  <= size_c[c];
                            cnt_q[c]   <= WR_LOAD;
                            state_q[c] <= (WRITE_LAT == 1) ? RESP : WR_WAIT;
                        end
                    end
                    RD_WAIT, WR_WAIT: begin
                        if (cnt_q[c] == CNT_W'(1)) state_q[c] <= RESP;
                        else cnt_q[c] <= cnt_q[c] - CNT_W'(1);
                    end
                    RESP:    state_q[c] <= IDLE;
                    default: state_q[c] <= IDLE;
                endcase
            end
        end
    end

`ifdef MEM_SLAVE_PROTO_CHECK_EN
    always_ff @(posedge clock or posedge reset) begin
        if (reset) proto_q <= 1'b0;
        else if (|both_req) proto_q <= 1'b1;
    end
    assign proto_err = proto_q;
`else
    assign proto_err = 1'b0;
`endif

    assign M_DataRdy   = rdy_q;
    assign M_Rdata_ram = {rdata_q[1], rdata_q[0]};
endmodule

// File: tb/tb_bambu_offchip_mem_slave.sv
// Scoreboard bench for bambu_offchip_mem_slave with default parameters (READ_LAT=2, WRITE_LAT=1).
module tb_bambu_offchip_mem_slave;
    logic        clock = 1'b0;
    logic        reset = 1'b1;
    logic [1:0]  oe, we;
    logic [21:0] addr;
    logic [15:0] wdata;
    logic [7:0]  size;
    logic [15:0] rdata;
    logic [1:0]  rdy;
    logic        ld_en;
    logic [10:0] ld_addr;
    logic [7:0]  ld_data;
    logic        proto_err;

    int errors = 0;
    int checks = 0;

    typedef struct { int lat; logic [7:0] data; } exp_t;
    exp_t exp_q[$];

    always #5 clock = ~clock;

    bambu_offchip_mem_slave dut (
        .clock(clock), .reset(reset),
        .Mout_oe_ram(oe), .Mout_we_ram(we), .Mout_addr_ram(addr),
        .Mout_Wdata_ram(wdata), .Mout_data_ram_size(size),
        .M_Rdata_ram(rdata), .M_DataRdy(rdy),
        .ld_en(ld_en), .ld_addr(ld_addr), .ld_data(ld_data),
        .proto_err(proto_err)
    );

    initial begin
        #300000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    task automatic idle_bus();
        oe = '0; we = '0; addr = '0; wdata = '0; size = '0;
        ld_en = 1'b0; ld_addr = '0; ld_data = '0;
    endtask

    task automatic set_ch(input int ch, input logic o, input logic w, input logic [10:0] a,
                          input logic [7:0] d, input logic [3:0] s);
        oe[ch] = o; we[ch] = w;
        addr[ch*11 +: 11] = a;
        wdata[ch*8 +: 8]  = d;
        size[ch*4 +: 4]   = s;
    endtask

    task automatic load(input logic [10:0] a, input logic [7:0] d);
        ld_en = 1'b1; ld_addr = a; ld_data = d;
        @(posedge clock); #1;
        ld_en = 1'b0;
    endtask

    // Issue one request, hold it until DataRdy or maxwait cycles; lat=-1 when no response arrives.
    task automatic run_access(input int ch, input logic o, input logic w, input logic [10:0] a,
                              input logic [7:0] d, input logic [3:0] s, input int maxwait,
                              output int lat, output logic [7:0] data);
        set_ch(ch, o, w, a, d, s);
        lat = -1; data = '0;
        @(posedge clock);
        for (int i = 1; i <= maxwait; i++) begin
            @(negedge clock);
            if (rdy[ch]) begin
                lat = i; data = rdata[ch*8 +: 8];
                break;
            end
        end
        set_ch(ch, 1'b0, 1'b0, 11'd0, 8'd0, 4'd0);
        @(posedge clock); #1;
    endtask

    task automatic test_reset();
        idle_bus();
        reset = 1'b1;
        repeat (3) @(posedge clock);
        #1 reset = 1'b0;
        for (int i = 0; i < 20; i++) begin
            @(negedge clock);
            checks++;
            if (rdy !== 2'b00) begin errors++; $display("FAIL reset_rdy cyc%0d: got %b expected 00", i, rdy); end
            checks++;
            if (rdata !== 16'h0) begin errors++; $display("FAIL reset_rdata cyc%0d: got %h expected 0000", i, rdata); end
        end
        checks++;
        if (proto_err !== 1'b0) begin errors++; $display("FAIL reset_proto: got %b expected 0", proto_err); end
        @(posedge clock); #1;
    endtask

    task automatic test_read();
        int lat; logic [7:0] d; exp_t e;
        load(11'd5, 8'hA5);
        exp_q.push_back('{2, 8'hA5});
        run_access(0, 1'b1, 1'b0, 11'd5, 8'h00, 4'd8, 8, lat, d);
        e = exp_q.pop_front();
        checks++;
        if (lat !== e.lat) begin errors++; $display("FAIL read_lat: got %0d expected %0d", lat, e.lat); end
        checks++;
        if (d !== e.data) begin errors++; $display("FAIL read_data: got %h expected %h", d, e.data); end
        @(negedge clock);
        checks++;
        if (rdy[0] !== 1'b0 || rdata[7:0] !== 8'h00) begin
            errors++; $display("FAIL read_single_cycle: got rdy=%b data=%h expected 0/00", rdy[0], rdata[7:0]);
        end
        @(posedge clock); #1;
        exp_q.push_back('{2, 8'h05});
        run_access(0, 1'b1, 1'b0, 11'd5, 8'h00, 4'd4, 8, lat, d);
        e = exp_q.pop_front();
        checks++;
        if (lat !== e.lat || d !== e.data) begin
            errors++; $display("FAIL read_masked: got lat=%0d data=%h expected %0d/%h", lat, d, e.lat, e.data);
        end
        load(11'd511, 8'h5A);
        exp_q.push_back('{2, 8'h5A});
        run_access(1, 1'b1, 1'b0, 11'd511, 8'h00, 4'd8, 8, lat, d);
        e = exp_q.pop_front();
        checks++;
        if (lat !== e.lat || d !== e.data) begin
            errors++; $display("FAIL read_top_index: got lat=%0d data=%h expected %0d/%h", lat, d, e.lat, e.data);
        end
    endtask

    task automatic test_partial_write();
        int lat; logic [7:0] d; exp_t e;
        load(11'd7, 8'h00);
        exp_q.push_back('{1, 8'h00});
        run_access(1, 1'b0, 1'b1, 11'd7, 8'hFF, 4'd4, 8, lat, d);
        e = exp_q.pop_front();
        checks++;
        if (lat !== e.lat || d !== e.data) begin
            errors++; $display("FAIL write_resp: got lat=%0d data=%h expected %0d/%h", lat, d, e.lat, e.data);
        end
        exp_q.push_back('{2, 8'h0F});
        run_access(1, 1'b1, 1'b0, 11'd7, 8'h00, 4'd8, 8, lat, d);
        e = exp_q.pop_front();
        checks++;
        if (lat !== e.lat || d !== e.data) begin
            errors++; $display("FAIL partial_write_readback: got lat=%0d data=%h expected %0d/%h", lat, d, e.lat, e.data);
        end
    endtask

    task automatic test_same_index();
        int lat; logic [7:0] d; exp_t e;
        set_ch(0, 1'b0, 1'b1, 11'd3, 8'h11, 4'd8);
        set_ch(1, 1'b0, 1'b1, 11'd3, 8'h22, 4'd8);
        @(posedge clock);
        @(negedge clock);
        checks++;
        if (rdy !== 2'b11) begin errors++; $display("FAIL dual_write_rdy: got %b expected 11", rdy); end
        set_ch(0, 1'b0, 1'b0, 11'd0, 8'd0, 4'd0);
        set_ch(1, 1'b0, 1'b0, 11'd0, 8'd0, 4'd0);
        @(posedge clock); #1;
        exp_q.push_back('{2, 8'h22});
        run_access(0, 1'b1, 1'b0, 11'd3, 8'h00, 4'd8, 8, lat, d);
        e = exp_q.pop_front();
        checks++;
        if (lat !== e.lat || d !== e.data) begin
            errors++; $display("FAIL dual_write_winner: got lat=%0d data=%h expected %0d/%h", lat, d, e.lat, e.data);
        end
    endtask

    task automatic test_read_write_same_edge();
        int lat0 = -1; logic [7:0] d0 = '0;
        load(11'd10, 8'h44);
        set_ch(0, 1'b1, 1'b0, 11'd10, 8'h00, 4'd8);
        set_ch(1, 1'b0, 1'b1, 11'd10, 8'h99, 4'd8);
        @(posedge clock);
        for (int i = 1; i <= 6; i++) begin
            @(negedge clock);
            if (rdy[1]) set_ch(1, 1'b0, 1'b0, 11'd0, 8'd0, 4'd0);
            if (rdy[0] && lat0 < 0) begin lat0 = i; d0 = rdata[7:0]; set_ch(0, 1'b0, 1'b0, 11'd0, 8'd0, 4'd0); end
        end
        set_ch(0, 1'b0, 1'b0, 11'd0, 8'd0, 4'd0);
        set_ch(1, 1'b0, 1'b0, 11'd0, 8'd0, 4'd0);
        @(posedge clock); #1;
        checks++;
        if (lat0 !== 2 || d0 !== 8'h99) begin
            errors++; $display("FAIL read_during_write: got lat=%0d data=%h expected 2/99", lat0, d0);
        end
    endtask

    task automatic test_loader();
        int lat; logic [7:0] d; exp_t e;
        ld_en = 1'b1; ld_addr = 11'd20; ld_data = 8'hAA;
        set_ch(0, 1'b0, 1'b1, 11'd20, 8'hBB, 4'd8);
        @(posedge clock); #1;
        ld_en = 1'b0;
        @(negedge clock);
        set_ch(0, 1'b0, 1'b0, 11'd0, 8'd0, 4'd0);
        @(posedge clock); #1;
        exp_q.push_back('{2, 8'hBB});
        run_access(0, 1'b1, 1'b0, 11'd20, 8'h00, 4'd8, 8, lat, d);
        e = exp_q.pop_front();
        checks++;
        if (lat !== e.lat || d !== e.data) begin
            errors++; $display("FAIL loader_vs_channel: got lat=%0d data=%h expected %0d/%h", lat, d, e.lat, e.data);
        end
        load(11'd88, 8'h77);
        load(11'd600, 8'hEE);
        exp_q.push_back('{2, 8'h77});
        run_access(1, 1'b1, 1'b0, 11'd88, 8'h00, 4'd8, 8, lat, d);
        e = exp_q.pop_front();
        checks++;
        if (lat !== e.lat || d !== e.data) begin
            errors++; $display("FAIL loader_drop: got lat=%0d data=%h expected %0d/%h", lat, d, e.lat, e.data);
        end
    endtask

    task automatic test_out_of_window();
        int lat; logic [7:0] d;
        run_access(0, 1'b1, 1'b0, 11'd512, 8'h00, 4'd8, 10, lat, d);
        checks++;
        if (lat !== -1) begin errors++; $display("FAIL oow_read: got lat=%0d expected none(-1)", lat); end
        run_access(1, 1'b0, 1'b1, 11'd1500, 8'h12, 4'd8, 10, lat, d);
        checks++;
        if (lat !== -1) begin errors++; $display("FAIL oow_write: got lat=%0d expected none(-1)", lat); end
    endtask

    task automatic test_reset_abort();
        int lat; logic [7:0] d; exp_t e;
        logic seen = 1'b0;
        set_ch(0, 1'b1, 1'b0, 11'd5, 8'h00, 4'd8);
        @(posedge clock); #1;
        reset = 1'b1;
        set_ch(0, 1'b0, 1'b0, 11'd0, 8'd0, 4'd0);
        @(posedge clock); #1;
        reset = 1'b0;
        for (int i = 0; i < 5; i++) begin
            @(negedge clock);
            seen |= rdy[0];
        end
        checks++;
        if (seen !== 1'b0) begin errors++; $display("FAIL abort_no_rdy: got %b expected 0", seen); end
        @(posedge clock); #1;
        exp_q.push_back('{2, 8'hA5});
        run_access(0, 1'b1, 1'b0, 11'd5, 8'h00, 4'd8, 8, lat, d);
        e = exp_q.pop_front();
        checks++;
        if (lat !== e.lat || d !== e.data) begin
            errors++; $display("FAIL after_abort_read: got lat=%0d data=%h expected %0d/%h", lat, d, e.lat, e.data);
        end
    endtask

    task automatic test_back_to_back();
        exp_t e;
        exp_q.push_back('{2, 8'hA5});
        exp_q.push_back('{5, 8'hA5});
        exp_q.push_back('{8, 8'hA5});
        set_ch(0, 1'b1, 1'b0, 11'd5, 8'h00, 4'd8);
        @(posedge clock);
        for (int i = 1; i <= 9; i++) begin
            @(negedge clock);
            if (rdy[0]) begin
                checks++;
                if (exp_q.size() == 0) begin
                    errors++; $display("FAIL b2b_extra: got pulse at cycle %0d expected none", i);
                end else begin
                    e = exp_q.pop_front();
                    if (i !== e.lat || rdata[7:0] !== e.data) begin
                        errors++; $display("FAIL b2b_pulse: got cycle=%0d data=%h expected %0d/%h", i, rdata[7:0], e.lat, e.data);
                    end
                end
            end
        end
        set_ch(0, 1'b0, 1'b0, 11'd0, 8'd0, 4'd0);
        checks++;
        if (exp_q.size() != 0) begin errors++; $display("FAIL b2b_missing: got %0d unmatched expected 0", exp_q.size()); end
        exp_q.delete();
        @(posedge clock); #1;
    endtask

    task automatic test_proto();
        int lat; logic [7:0] d; exp_t e;
        load(11'd9, 8'h00);
`ifdef MEM_SLAVE_PROTO_CHECK_EN
        run_access(0, 1'b1, 1'b1, 11'd9, 8'h3C, 4'd8, 6, lat, d);
        checks++;
        if (lat !== -1) begin errors++; $display("FAIL proto_no_rdy: got lat=%0d expected none(-1)", lat); end
        checks++;
        if (proto_err !== 1'b1) begin errors++; $display("FAIL proto_set: got %b expected 1", proto_err); end
        exp_q.push_back('{2, 8'h00});
`else
        exp_q.push_back('{1, 8'h00});
        run_access(0, 1'b1, 1'b1, 11'd9, 8'h3C, 4'd8, 6, lat, d);
        e = exp_q.pop_front();
        checks++;
        if (lat !== e.lat || d !== e.data) begin
            errors++; $display("FAIL oe_we_as_write: got lat=%0d data=%h expected %0d/%h", lat, d, e.lat, e.data);
        end
        exp_q.push_back('{2, 8'h3C});
`endif
        run_access(0, 1'b1, 1'b0, 11'd9, 8'h00, 4'd8, 8, lat, d);
        e = exp_q.pop_front();
        checks++;
        if (lat !== e.lat || d !== e.data) begin
            errors++; $display("FAIL proto_readback: got lat=%0d data=%h expected %0d/%h", lat, d, e.lat, e.data);
        end
`ifdef MEM_SLAVE_PROTO_CHECK_EN
        checks++;
        if (proto_err !== 1'b1) begin errors++; $display("FAIL proto_sticky: got %b expected 1", proto_err); end
        reset = 1'b1;
        @(posedge clock); #1;
        reset = 1'b0;
`endif
        @(negedge clock);
        checks++;
        if (proto_err !== 1'b0) begin errors++; $display("FAIL proto_clear: got %b expected 0", proto_err); end
        @(posedge clock); #1;
    endtask

    initial begin
        test_reset();
        test_read();
        test_partial_write();
        test_same_index();
        test_read_write_same_edge();
        test_loader();
        test_out_of_window();
        test_reset_abort();
        test_back_to_back();
        test_proto();
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end
endmodule
